// File: rtl/act_max_buffer.sv
// Frame buffer that stores a float32 activation frame, tracks its absolute maximum,
// then replays the frame in order with the max held on o_max. Optional: ACT_MAX_NAN_FILTER_EN.
module act_max_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_activation,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_activation,
  output logic [31:0] o_max,
  output logic        o_last,
  output logic        o_trunc
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAG_W  = 31;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MAG_W-1:0]    run_max_q, run_max_d;
  logic [DATA_W-1:0]   max_out_q, max_out_d;
  logic                trunc_q, trunc_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic                take_mag;
  logic [MAG_W-1:0]    upd_max;
  logic                last_c;
  logic                full_c;

  // NaN inputs may be excluded from the magnitude compare
`ifdef ACT_MAX_NAN_FILTER_EN
  assign take_mag = !((i_activation[30:23] == 8'hFF) && (i_activation[22:0] != 23'd0));
`else
  assign take_mag = 1'b1;
`endif

  assign upd_max = (take_mag && (i_activation[30:0] > run_max_q)) ? i_activation[30:0] : run_max_q;
  assign full_c  = (wr_ptr_q == ADDR_W'(DEPTH - 1));
  assign last_c  = (state_q == DRAIN) && (rd_ptr_q == (wr_ptr_q - ADDR_W'(1)));

  assign o_ready      = (state_q == FILL);
  assign o_valid      = (state_q == DRAIN);
  assign o_activation = mem_q[rd_ptr_q];
  assign o_max        = max_out_q;
  assign o_last       = last_c;
  assign o_trunc      = trunc_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    run_max_d = run_max_q;
    max_out_d = max_out_q;
    trunc_d   = trunc_q;
    mem_we    = 1'b0;
    case (state_q)
      FILL: begin
        if (i_valid) begin
          mem_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          run_max_d = upd_max;
          if (i_last || full_c) begin
            state_d   = DRAIN;
            rd_ptr_d  = '0;
            max_out_d = {1'b0, upd_max};
            if (!i_last) trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (i_ready) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          // Final word consumed: rearm for the next frame, o_max keeps its value
          if (last_c) begin
            state_d   = FILL;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            run_max_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      run_max_q <= '0;
      max_out_q <= '0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      run_max_q <= run_max_d;
      max_out_q <= max_out_d;
      trunc_q   <= trunc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= i_activation;
    end
  end

endmodule

// File: tb/tb_act_max_buffer.sv
// Scoreboard bench for act_max_buffer: expected replay words are queued as frames are driven.
module tb_act_max_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_activation;
  logic        i_last;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_activation;
  logic [31:0] o_max;
  logic        o_last;
  logic        o_trunc;

  act_max_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_activation (i_activation),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_activation (o_activation),
    .o_max        (o_max),
    .o_last       (o_last),
    .o_trunc      (o_trunc)
  );

  typedef struct packed {
    logic [31:0] act;
    logic [31:0] max;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] frame_q[$];
  logic [30:0] m_max;
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan_f(input logic [31:0] a);
`ifdef ACT_MAX_NAN_FILTER_EN
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one input word; on frame close the reference model queues the replay
  task automatic put_word(input logic [31:0] act, input logic last);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    i_valid      = 1'b1;
    i_activation = act;
    i_last       = last;
    frame_q.push_back(act);
    if (!is_nan_f(act) && act[30:0] > m_max) m_max = act[30:0];
    if (last || frame_q.size() == DEPTH) begin
      foreach (frame_q[i]) begin
        exp_t e;
        e.act  = frame_q[i];
        e.max  = {1'b0, m_max};
        e.last = (i == frame_q.size() - 1);
        sb_q.push_back(e);
      end
      frame_q.delete();
      m_max = '0;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Pop and compare replayed words; stop_after < 0 drains the whole queue
  task automatic drain(input bit toggle, input int stop_after);
    int   popped;
    int   budget;
    bit   ph;
    exp_t e;
    popped = 0;
    budget = 0;
    ph     = 1'b0;
    check("valid_latency", 32'(o_valid), 32'd1);
    while (sb_q.size() > 0 && popped != stop_after && budget < 300) begin
      i_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      e = sb_q[0];
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_act", o_activation, e.act);
      check("drain_max", o_max, e.max);
      check("drain_last", 32'(o_last), 32'(e.last));
      if (i_ready) begin
        void'(sb_q.pop_front());
        popped++;
      end
      @(posedge clk); #1;
      budget++;
    end
    i_ready = 1'b0;
    if (budget >= 300) begin
      check("drain_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    if (stop_after < 0) begin
      check("ready_after_drain", 32'(o_ready), 32'd1);
      check("valid_after_drain", 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    m_max        = '0;
    reset        = 1'b1;
    i_valid      = 1'b0;
    i_activation = '0;
    i_last       = 1'b0;
    i_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_trunc", 32'(o_trunc), 32'd0);
    check("rst_max", o_max, 32'd0);
    check("rst_act", o_activation, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic three-word frame
    put_word(32'h41000000, 1'b0);
    put_word(32'h43800000, 1'b0);
    put_word(32'h3F800000, 1'b1);
    check("f1_max", o_max, 32'h43800000);
    drain(1'b0, -1);
    check("f1_trunc", 32'(o_trunc), 32'd0);

    // Negative word dominates; sign preserved on replay
    put_word(32'h43800000, 1'b0);
    put_word(32'hC4000000, 1'b1);
    check("f2_max", o_max, 32'h44000000);
    drain(1'b0, -1);

    // Full-depth frame without i_last
    for (int i = 0; i < DEPTH; i++)
      put_word(32'h40000000 | (32'(i) << 20) | ((i % 2 == 1) ? 32'h80000000 : 32'h0), 1'b0);
    check("f3_trunc", 32'(o_trunc), 32'd1);
    check("f3_max", o_max, 32'h40F00000);
    drain(1'b0, -1);
    put_word(32'h41000000, 1'b1);
    check("f4_max", o_max, 32'h41000000);
    check("f4_trunc_sticky", 32'(o_trunc), 32'd1);
    drain(1'b0, -1);

    // Downstream stall every other cycle
    put_word(32'h3F800000, 1'b0);
    put_word(32'hC2C80000, 1'b0);
    put_word(32'h40400000, 1'b0);
    put_word(32'h00000000, 1'b1);
    drain(1'b1, -1);

    // Reset in the middle of a drain
    put_word(32'h41000000, 1'b0);
    put_word(32'h42000000, 1'b0);
    put_word(32'h43000000, 1'b0);
    put_word(32'h44000000, 1'b1);
    drain(1'b0, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_max", o_max, 32'd0);
    check("mid_rst_act", o_activation, 32'd0);
    check("mid_rst_trunc", 32'(o_trunc), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    put_word(32'h3F800000, 1'b1);
    check("f6_max", o_max, 32'h3F800000);
    drain(1'b0, -1);

    // NaN handling
    put_word(32'h7FC00000, 1'b0);
    put_word(32'h41000000, 1'b1);
`ifdef ACT_MAX_NAN_FILTER_EN
    check("nan_max", o_max, 32'h41000000);
`else
    check("nan_max", o_max, 32'h7FC00000);
`endif
    drain(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
